mem_lsu: RTL and testbench
==========================

# mem_lsu

- Parametrised load/store unit for the MEM stage.
- Accepts one access per `MEM_Enable` pulse from the ALU stage and drives a single-outstanding read or write request towards the AXI4 bridge.
- Generates byte-lane strobes and lane-shifted store data, and aligns, sign-extends or zero-extends load data.
- Returns a registered `RESULT` with a one-cycle `FINISH` pulse.

## Interface
- `XLEN`, 64: data width; 32 or 64. Byte lanes `NB = XLEN/8`.
- `ADDR_W`, 64: address width.
- `clk` in 1: clock; all logic on rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `MEM_Enable` in 1: start-access strobe; sampled only in IDLE.
- `Ctrl` in 4: [3] = 1 store / 0 load; [2] = 1 zero-extend (loads only; ignored for stores); [1:0] size: 0 = B, 1 = H, 2 = W, 3 = D.
- `MEM_ADDR_FROM_ALU` in ADDR_W: byte address.
- `MEM_DATA_FROM_ALU` in XLEN: store data, LSB-justified.
- `MEM_READ_REQ` out 1: read request, level, held until finish.
- `MEM_READ_FINISH` in 1: read done; data valid this cycle.
- `MEM_READ_ADDR` out ADDR_W: word-aligned read address.
- `MEM_READ_DATA` in XLEN: full bus word.
- `MEM_WRITE_REQ` out 1: write request, level, held until finish.
- `MEM_WRITE_FINISH` in 1: write done.
- `MEM_WRITE_ADDR` out ADDR_W: word-aligned write address.
- `MEM_WRITE_DATA` out XLEN: lane-shifted store data.
- `MEM_WRITE_STRB` out NB: byte-lane enables.
- `RESULT` out XLEN: extended load data; holds last value.
- `FINISH` out 1: one-cycle completion pulse.
- `BUSY` out 1: high in any state other than IDLE.
- `MISALIGN` out 1: qualifies `FINISH`; access was rejected.

## Operation
- **States:** IDLE, RD_WAIT, WR_WAIT, DONE.
- **IDLE capture:** in IDLE with `MEM_Enable` = 1, the unit latches `Ctrl`, the address and the store data.
- **IDLE dispatch:**
  - Load goes to RD_WAIT.
  - Store goes to WR_WAIT.
  - A misaligned access goes directly to DONE with a misalign flag set; no bus request is issued.
- **Size clamp:** size 3 with `XLEN`=32 is treated as size 2.
- **Misalignment rule:** `addr mod (1<<size) != 0`.
- **Bus addresses:** `MEM_*_ADDR` = address with the low `log2(NB)` bits cleared.
- **Lane offset:** `off` = address low `log2(NB)` bits.
- **Write strobes:** `MEM_WRITE_STRB` = `((1<<(1<<size))-1) << off`.
- **Write data:** `MEM_WRITE_DATA` = store data `<< (8*off)`; bytes outside the strobe are don't-care and are driven as replicated data.
- **RD_WAIT:** on `MEM_READ_FINISH`, `MEM_READ_DATA >> (8*off)` is truncated to the access size and extended per `Ctrl[2]`, written to the `RESULT` register, and the FSM goes to DONE.
- **WR_WAIT:** on `MEM_WRITE_FINISH`, the FSM goes to DONE; `RESULT` is unchanged.
- **DONE:** `FINISH` = 1 for exactly one cycle, `MISALIGN` = misalign flag, then IDLE.
- **Ignored inputs:**
  - `MEM_Enable` outside IDLE.
  - `*_FINISH` when the corresponding request is low.
  - `MEM_WRITE_FINISH` in RD_WAIT, and vice versa.
- **Reset values:**
  - FSM = IDLE.
  - `MEM_READ_REQ`, `MEM_WRITE_REQ`, `FINISH`, `MISALIGN`, `BUSY` = 0.
  - `RESULT` = 0.
  - `MEM_*_ADDR` = 0, `MEM_WRITE_DATA` = 0, `MEM_WRITE_STRB` = 0.
- **Reset mid-access:** reset asserted during an access drops the request asynchronously; the in-flight access is abandoned and no `FINISH` is produced.

## Timing
- **Request launch:** `MEM_Enable` sampled at edge N; `*_REQ` is high from N+1.
- **Request hold:** the request, address, data and strobe are stable until finish is sampled.
- **Request drop:** finish sampled at edge M; `*_REQ` is low from M+1, `FINISH` is high during M+1 to M+2.
- **Minimum latency:** with finish in the first request cycle, Enable edge N gives `FINISH` in cycle N+2.
- **Misaligned access:** `FINISH` and `MISALIGN` are high in cycle N+1; no request is issued.
- **Back-to-back:** the next access may be presented in the `FINISH` cycle. It is ignored because the FSM is in DONE; it is accepted from IDLE one cycle later.
- **Throughput:** the fastest rate is 1 access per 3 cycles.
- **Outputs:** all are registered; no combinational input-to-output path.

## Configuration
- **Macro:** `MEM_MISALIGN_TRAP_EN`.
- **Defined:** misaligned accesses are rejected with `MISALIGN` as described above.
- **Undefined:**
  - `MISALIGN` is tied to 0.
  - Address bits below the access size are cleared, forcing natural alignment.
  - The access proceeds normally with the cleared address; no access is ever rejected.

## Test plan
All cases use `XLEN`=64.
- **Signed byte load:** Load B, addr 0x8000_0003, `MEM_READ_DATA` = 0x1122_3344_8566_7788, finish after 3 request cycles.
  - `MEM_READ_ADDR` = 0x8000_0000.
  - `RESULT` = 0xFFFF_FFFF_FFFF_FF85, one `FINISH` pulse, `MISALIGN` = 0.
- **Zero-extend word load:** Load W, `Ctrl[2]` = 1, addr 0x8000_0004, same data → `RESULT` = 0x0000_0000_1122_3344.
- **Halfword store:** Store H, addr 0x8000_0006, data 0xABCD → `MEM_WRITE_STRB` = 0xC0, `MEM_WRITE_DATA[63:48]` = 0xABCD, request held until `MEM_WRITE_FINISH`, `RESULT` unchanged.
- **Misaligned load (trap):** Load D, addr 0x8000_0004, with `MEM_MISALIGN_TRAP_EN` → no `REQ` ever, `FINISH` and `MISALIGN` high in cycle N+1.
- **Misaligned load (no trap):** same access without the macro → read issued at 0x8000_0000, `MISALIGN` = 0.
- **Reset and back-to-back:**
  - Assert `rst`=0 while `MEM_READ_REQ` = 1 → REQ low immediately, no `FINISH`, FSM IDLE after release.
  - `MEM_Enable` held high across the `FINISH` cycle → second access starts only from IDLE; exactly 2 `FINISH` pulses.

Source files
------------

// File: rtl/mem_lsu.sv
// Load/store unit for the MEM stage: one outstanding bus read or write per MEM_Enable.
// Latency: request from the cycle after Enable; FINISH one cycle after bus finish (misaligned: next cycle).
// Backpressure: request held until *_FINISH; MEM_Enable ignored while BUSY. Macro: MEM_MISALIGN_TRAP_EN.
module mem_lsu #(
  parameter int XLEN   = 64,
  parameter int ADDR_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MEM_Enable,
  input  logic [3:0]        Ctrl,
  input  logic [ADDR_W-1:0] MEM_ADDR_FROM_ALU,
  input  logic [XLEN-1:0]   MEM_DATA_FROM_ALU,
  output logic              MEM_READ_REQ,
  input  logic              MEM_READ_FINISH,
  output logic [ADDR_W-1:0] MEM_READ_ADDR,
  input  logic [XLEN-1:0]   MEM_READ_DATA,
  output logic              MEM_WRITE_REQ,
  input  logic              MEM_WRITE_FINISH,
  output logic [ADDR_W-1:0] MEM_WRITE_ADDR,
  output logic [XLEN-1:0]   MEM_WRITE_DATA,
  output logic [XLEN/8-1:0] MEM_WRITE_STRB,
  output logic [XLEN-1:0]   RESULT,
  output logic              FINISH,
  output logic              BUSY,
  output logic              MISALIGN
);
  localparam int NB = XLEN / 8;
  localparam int LW = $clog2(NB);

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, DONE} state_t;

  state_t            state_q, state_d;
  logic [1:0]        size_q, size_d;
  logic              zext_q, zext_d;
  logic [LW-1:0]     off_q, off_d;
  logic              rreq_q, rreq_d, wreq_q, wreq_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d, waddr_q, waddr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [NB-1:0]     wstrb_q, wstrb_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              finish_q, finish_d, misalign_q, misalign_d, busy_q, busy_d;

  logic [1:0]        in_size;
  logic [ADDR_W-1:0] amask, eff_addr, word_addr;
  logic              in_mis;
  logic [LW-1:0]     in_off;
  logic [NB-1:0]     in_strb;
  logic [XLEN-1:0]   in_wdata;
  int                nbytes;

  // Decode the incoming access: clamped size, alignment, lane offset, strobes, replicated store data
  always_comb begin
    in_size = Ctrl[1:0];
    if (XLEN == 32 && in_size == 2'd3) in_size = 2'd2;
    amask = (ADDR_W'(1) << in_size) - ADDR_W'(1);
`ifdef MEM_MISALIGN_TRAP_EN
    in_mis   = |(MEM_ADDR_FROM_ALU & amask);
    eff_addr = MEM_ADDR_FROM_ALU;
`else
    in_mis   = 1'b0;
    eff_addr = MEM_ADDR_FROM_ALU & ~amask;
`endif
    in_off    = eff_addr[LW-1:0];
    word_addr = eff_addr & ~ADDR_W'(NB - 1);
    nbytes    = 1 << in_size;
    in_strb   = '0;
    in_wdata  = '0;
    // Replicating the sized datum across every lane puts it in the strobed lanes for free
    for (int i = 0; i < NB; i++) begin
      in_strb[i] = (i >= int'(in_off)) && (i < int'(in_off) + nbytes);
      in_wdata[8*i +: 8] = MEM_DATA_FROM_ALU[8*(i & (nbytes - 1)) +: 8];
    end
  end

  logic [XLEN-1:0] rd_shift, ld_ext;
  logic            sign_bit;
  int              nbits;

  // Align returned read data to bit 0 and extend to XLEN
  always_comb begin
    rd_shift = MEM_READ_DATA >> {off_q, 3'b000};
    case (size_q)
      2'd0:    sign_bit = rd_shift[7];
      2'd1:    sign_bit = rd_shift[15];
      2'd2:    sign_bit = rd_shift[31];
      default: sign_bit = rd_shift[XLEN-1];
    endcase
    sign_bit = sign_bit & ~zext_q;
    nbits    = 8 << size_q;
    ld_ext   = '0;
    for (int i = 0; i < XLEN; i++) ld_ext[i] = (i < nbits) ? rd_shift[i] : sign_bit;
  end

  // Next-state and next-output logic for the access FSM
  always_comb begin
    state_d    = state_q;
    size_d     = size_q;
    zext_d     = zext_q;
    off_d      = off_q;
    rreq_d     = rreq_q;
    wreq_d     = wreq_q;
    raddr_d    = raddr_q;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    result_d   = result_q;
    finish_d   = 1'b0;
    misalign_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (MEM_Enable) begin
          size_d = in_size;
          zext_d = Ctrl[2];
          off_d  = in_off;
          if (in_mis) begin
            state_d    = DONE;
            finish_d   = 1'b1;
            misalign_d = 1'b1;
          end else if (Ctrl[3]) begin
            state_d = WR_WAIT;
            wreq_d  = 1'b1;
            waddr_d = word_addr;
            wdata_d = in_wdata;
            wstrb_d = in_strb;
          end else begin
            state_d = RD_WAIT;
            rreq_d  = 1'b1;
            raddr_d = word_addr;
          end
        end
      end
      RD_WAIT: begin
        if (MEM_READ_FINISH && rreq_q) begin
          state_d  = DONE;
          rreq_d   = 1'b0;
          result_d = ld_ext;
          finish_d = 1'b1;
        end
      end
      WR_WAIT: begin
        if (MEM_WRITE_FINISH && wreq_q) begin
          state_d  = DONE;
          wreq_d   = 1'b0;
          finish_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // All state and outputs registered; reset abandons any in-flight access
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      size_q     <= 2'd0;
      zext_q     <= 1'b0;
      off_q      <= '0;
      rreq_q     <= 1'b0;
      wreq_q     <= 1'b0;
      raddr_q    <= '0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      result_q   <= '0;
      finish_q   <= 1'b0;
      misalign_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      size_q     <= size_d;
      zext_q     <= zext_d;
      off_q      <= off_d;
      rreq_q     <= rreq_d;
      wreq_q     <= wreq_d;
      raddr_q    <= raddr_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      result_q   <= result_d;
      finish_q   <= finish_d;
      misalign_q <= misalign_d;
      busy_q     <= busy_d;
    end
  end

  assign MEM_READ_REQ   = rreq_q;
  assign MEM_READ_ADDR  = raddr_q;
  assign MEM_WRITE_REQ  = wreq_q;
  assign MEM_WRITE_ADDR = waddr_q;
  assign MEM_WRITE_DATA = wdata_q;
  assign MEM_WRITE_STRB = wstrb_q;
  assign RESULT         = result_q;
  assign FINISH         = finish_q;
  assign BUSY           = busy_q;
  assign MISALIGN       = misalign_q;
endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu (XLEN=64): scoreboard of expected RESULT/MISALIGN per access.
// Inputs driven and outputs sampled on the falling edge.
// Bus finish is driven by the scenario tasks; the opposite finish is pulsed to confirm it is ignored.
module tb_mem_lsu;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic [3:0]  ctrl = '0;
  logic [63:0] addr = '0, sdata = '0;
  logic        rreq, wreq, rfin = 1'b0, wfin = 1'b0;
  logic [63:0] raddr, waddr, wdata, result;
  logic [63:0] rdata = '0;
  logic [7:0]  wstrb;
  logic        finish, busy, misalign;

  typedef struct {
    logic [63:0] res;
    logic        mis;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int failures = 0;
  logic [63:0] last_result = '0;

  always #5 clk = ~clk;

  mem_lsu #(.XLEN(64), .ADDR_W(64)) dut (
    .clk(clk), .rst(rst), .MEM_Enable(en), .Ctrl(ctrl),
    .MEM_ADDR_FROM_ALU(addr), .MEM_DATA_FROM_ALU(sdata),
    .MEM_READ_REQ(rreq), .MEM_READ_FINISH(rfin), .MEM_READ_ADDR(raddr), .MEM_READ_DATA(rdata),
    .MEM_WRITE_REQ(wreq), .MEM_WRITE_FINISH(wfin), .MEM_WRITE_ADDR(waddr),
    .MEM_WRITE_DATA(wdata), .MEM_WRITE_STRB(wstrb),
    .RESULT(result), .FINISH(finish), .BUSY(busy), .MISALIGN(misalign)
  );

  // Present one access for a single cycle; called just after a falling edge
  task automatic start(input logic [3:0] c, input logic [63:0] a, input logic [63:0] d);
    ctrl = c; addr = a; sdata = d; en = 1'b1;
    @(negedge clk);
    en = 1'b0;
  endtask

  task automatic serve_read(input logic [63:0] data, input int n, input logic [63:0] exp_addr, input string nm);
    for (int i = 0; i < n; i++) begin
      checks++;
      if (rreq !== 1'b1 || raddr !== exp_addr) begin
        failures++;
        $display("FAIL %s_rd_req cyc%0d: req=%b addr=%h, want req=1 addr=%h", nm, i, rreq, raddr, exp_addr);
      end
      wfin = 1'b1;
      if (i == n - 1) begin rfin = 1'b1; wfin = 1'b0; rdata = data; end
      else rdata = ~data;
      @(negedge clk);
    end
    rfin = 1'b0; wfin = 1'b0;
  endtask

  task automatic serve_write(input int n, input logic [63:0] exp_addr, input logic [7:0] exp_strb,
                             input logic [63:0] exp_data, input string nm);
    logic [63:0] m;
    m = '0;
    for (int b = 0; b < 8; b++) if (exp_strb[b]) m[8*b +: 8] = 8'hFF;
    for (int i = 0; i < n; i++) begin
      checks++;
      if (wreq !== 1'b1 || waddr !== exp_addr || wstrb !== exp_strb || (wdata & m) !== exp_data) begin
        failures++;
        $display("FAIL %s_wr_req cyc%0d: req=%b addr=%h strb=%h data=%h, want 1 %h %h %h",
                 nm, i, wreq, waddr, wstrb, wdata & m, exp_addr, exp_strb, exp_data);
      end
      rfin = 1'b1;
      if (i == n - 1) begin wfin = 1'b1; rfin = 1'b0; end
      @(negedge clk);
    end
    rfin = 1'b0; wfin = 1'b0;
  endtask

  // Expect FINISH now, compare against the scoreboard, then expect a single-cycle pulse
  task automatic check_done(input string nm);
    exp_t e;
    checks++;
    if (finish !== 1'b1 || sb.size() == 0) begin
      failures++;
      $display("FAIL %s_finish: finish=%b pending=%0d, want finish=1 pending>0", nm, finish, sb.size());
    end else begin
      e = sb.pop_front();
      checks++;
      if (result !== e.res || misalign !== e.mis) begin
        failures++;
        $display("FAIL %s_result: result=%h mis=%b, want %h %b", nm, result, misalign, e.res, e.mis);
      end
    end
    checks++;
    if (rreq !== 1'b0 || wreq !== 1'b0) begin
      failures++;
      $display("FAIL %s_req_drop: rreq=%b wreq=%b, want 0 0", nm, rreq, wreq);
    end
    @(negedge clk);
    checks++;
    if (finish !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_pulse: finish=%b busy=%b, want 0 0", nm, finish, busy);
    end
  endtask

  task automatic push(input logic [63:0] r, input logic m);
    exp_t e;
    e.res = r; e.mis = m;
    sb.push_back(e);
    last_result = r;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({rreq, wreq, finish, misalign, busy} !== 5'b0 || result !== '0 || raddr !== '0 ||
        waddr !== '0 || wdata !== '0 || wstrb !== '0) begin
      failures++;
      $display("FAIL reset_values: req=%b%b fin=%b mis=%b busy=%b res=%h ra=%h wa=%h wd=%h st=%h, want all 0",
               rreq, wreq, finish, misalign, busy, result, raddr, waddr, wdata, wstrb);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_loads();
    push(64'hFFFF_FFFF_FFFF_FF85, 1'b0);
    start(4'b0000, 64'h8000_0003, '0);
    serve_read(64'h1122_3344_8566_7788, 3, 64'h8000_0000, "ld_sb");
    check_done("ld_sb");
    push(64'h0000_0000_1122_3344, 1'b0);
    start(4'b0110, 64'h8000_0004, '0);
    serve_read(64'h1122_3344_8566_7788, 1, 64'h8000_0000, "ld_wu");
    check_done("ld_wu");
    push(64'hFFFF_FFFF_FFFF_8566, 1'b0);
    start(4'b0001, 64'h8000_0002, '0);
    serve_read(64'h1122_3344_8566_7788, 2, 64'h8000_0000, "ld_sh");
    check_done("ld_sh");
  endtask

  task automatic test_stores();
    push(last_result, 1'b0);
    start(4'b1001, 64'h8000_0006, 64'h0000_0000_0000_ABCD);
    serve_write(4, 64'h8000_0000, 8'hC0, 64'hABCD_0000_0000_0000, "st_h");
    check_done("st_h");
    push(last_result, 1'b0);
    start(4'b1111, 64'h8000_0008, 64'h0123_4567_89AB_CDEF);
    serve_write(1, 64'h8000_0008, 8'hFF, 64'h0123_4567_89AB_CDEF, "st_d");
    check_done("st_d");
  endtask

  task automatic test_misaligned();
`ifdef MEM_MISALIGN_TRAP_EN
    push(last_result, 1'b1);
    start(4'b0011, 64'h8000_0004, '0);
    check_done("mis_trap");
    checks++;
    if (rreq !== 1'b0 || wreq !== 1'b0) begin
      failures++;
      $display("FAIL mis_trap_noreq: rreq=%b wreq=%b, want 0 0", rreq, wreq);
    end
`else
    push(64'h1122_3344_8566_7788, 1'b0);
    start(4'b0011, 64'h8000_0004, '0);
    serve_read(64'h1122_3344_8566_7788, 1, 64'h8000_0000, "mis_notrap");
    check_done("mis_notrap");
`endif
  endtask

  task automatic test_reset_mid_access();
    start(4'b0000, 64'h8000_0001, '0);
    checks++;
    if (rreq !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_pre: rreq=%b, want 1", rreq);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (rreq !== 1'b0 || busy !== 1'b0 || result !== '0) begin
      failures++;
      $display("FAIL rst_mid_async: rreq=%b busy=%b res=%h, want 0 0 0", rreq, busy, result);
    end
    last_result = '0;
    @(negedge clk);
    rst = 1'b1;
    rfin = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (finish !== 1'b0 || busy !== 1'b0 || rreq !== 1'b0) begin
        failures++;
        $display("FAIL rst_mid_idle cyc%0d: fin=%b busy=%b rreq=%b, want 0 0 0", i, finish, busy, rreq);
      end
    end
    rfin = 1'b0;
  endtask

  task automatic test_back_to_back();
    int pulses;
    exp_t e;
    pulses = 0;
    push(64'h77, 1'b0);
    push(64'h77, 1'b0);
    ctrl = 4'b0000; addr = 64'h8000_0001; rdata = 64'h1122_3344_8566_7788; en = 1'b1;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(negedge clk);
      if (finish === 1'b1) begin
        pulses++;
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL b2b_extra_finish cyc%0d: got finish, want none", cyc);
        end else begin
          e = sb.pop_front();
          if (result !== e.res || misalign !== e.mis) begin
            failures++;
            $display("FAIL b2b_result cyc%0d: res=%h mis=%b, want %h %b", cyc, result, misalign, e.res, e.mis);
          end
        end
      end
      if (cyc == 3) begin
        checks++;
        if (rreq !== 1'b0 || busy !== 1'b0) begin
          failures++;
          $display("FAIL b2b_idle_gap: rreq=%b busy=%b, want 0 0", rreq, busy);
        end
      end
      if (cyc == 4) en = 1'b0;
      rfin = rreq;
    end
    rfin = 1'b0;
    checks++;
    if (pulses != 2 || sb.size() != 0) begin
      failures++;
      $display("FAIL b2b_count: pulses=%0d pending=%0d, want 2 0", pulses, sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_loads();
    test_stores();
    test_misaligned();
    test_reset_mid_access();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
